// File: rtl/dma_rd_burst_engine_if.sv
// -----------------------------------------------------------------------------
// AxiPkg / AXI4ReadIntf
// Purpose : AXI4 read-channel payload types and the AR/R channel bundle used by
//           the DMA read engine.
// Ports   : Master modport drives RdAddrValid, RdAddrPayload, RdDataReady and
//           samples RdAddrReady, RdDataValid, RdDataPayload. Slave is the mirror.
// -----------------------------------------------------------------------------
package AxiPkg;
   localparam int AXI_ADDR_W = 64;
   localparam int AXI_DATA_W = 64;
   localparam int AXI_ID_W   = 4;

   localparam logic [1:0] BURST_INCR = 2'b01;

   typedef struct packed {
      logic [AXI_ID_W-1:0]   id;
      logic [AXI_ADDR_W-1:0] addr;
      logic [7:0]            len;
      logic [2:0]            size;
      logic [1:0]            burst;
   } AxiRdAddr_t;

   typedef struct packed {
      logic [AXI_ID_W-1:0]   id;
      logic [AXI_DATA_W-1:0] data;
      logic [1:0]            resp;
      logic                  last;
   } AxiRdData_t;
endpackage

interface AXI4ReadIntf;
   import AxiPkg::*;

   logic       RdAddrValid;
   logic       RdAddrReady;
   AxiRdAddr_t RdAddrPayload;
   logic       RdDataValid;
   logic       RdDataReady;
   AxiRdData_t RdDataPayload;

   modport Master (
      output RdAddrValid, RdAddrPayload, RdDataReady,
      input  RdAddrReady, RdDataValid, RdDataPayload
   );

   modport Slave (
      input  RdAddrValid, RdAddrPayload, RdDataReady,
      output RdAddrReady, RdDataValid, RdDataPayload
   );
endinterface

// File: rtl/dma_rd_burst_engine.sv
// -----------------------------------------------------------------------------
// dma_rd_burst_engine
// Purpose : Takes one (start address, byte count) command, splits it into AXI4
//           INCR bursts that never cross a 4 KiB page, keeps at most MAX_OUTST
//           bursts in flight and streams the returned beats to the datapath.
// Ports   : clk, rstn           clock, async active-low reset
//           cmd_*               command handshake (accepted only when idle)
//           out_*               data beat stream, out_last marks final beat
//           busy / done / err   status; done is a one-cycle pulse, err sticky
//           rd                  AXI4 read master (AR and R channels)
// -----------------------------------------------------------------------------
module dma_rd_burst_engine
   import AxiPkg::*;
#(
   parameter int DATA_BYTES = 8,
   parameter int ADDR_W     = 64,
   parameter int LEN_W      = 32,
   parameter int MAX_BURST  = 16,
   parameter int MAX_OUTST  = 4,
   parameter int AXI_ID     = 0
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [ADDR_W-1:0]       cmd_addr,
   input  logic [LEN_W-1:0]        cmd_bytes,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [8*DATA_BYTES-1:0] out_data,
   output logic                    out_last,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   AXI4ReadIntf.Master             rd
);

   localparam int SHIFT = $clog2(DATA_BYTES);
   localparam int OUT_W = $clog2(MAX_OUTST + 1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(DATA_BYTES - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0]  remaining_q, remaining_d;
   logic [LEN_W-1:0]  beats_total_q, beats_total_d;
   logic [LEN_W-1:0]  beats_rcvd_q, beats_rcvd_d;
   logic [OUT_W-1:0]  outst_q, outst_d;
   logic              ar_valid_q, ar_valid_d;
   AxiRdAddr_t        ar_q, ar_d;
   logic              err_q, err_d;

   logic [LEN_W-1:0]  cmd_beats;
   logic [12:0]       page_beats;
   logic [12:0]       burst_beats;
   logic [LEN_W-1:0]  cur_beats;
   logic              ar_hs;
   logic              r_hs;
   logic              r_last_hs;
   logic              unused_r_fields;

   assign cmd_beats  = cmd_bytes >> SHIFT;
   // Beats left before the next 4 KiB page boundary.
   assign page_beats = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> SHIFT;
   // Beats carried by the AR currently presented (payload is held until accepted).
   assign cur_beats  = LEN_W'(ar_q.len) + LEN_W'(1);

   always_comb begin
      burst_beats = 13'(MAX_BURST);
      if (remaining_q < LEN_W'(burst_beats)) burst_beats = remaining_q[12:0];
      if (page_beats < burst_beats)          burst_beats = page_beats;
   end

   // R channel is a straight pass-through; gating by busy keeps stray beats
   // out of the datapath while idle.
   assign busy           = (state_q != IDLE);
   assign cmd_ready      = (state_q == IDLE);
   assign done           = (state_q == DONE);
   assign err            = err_q;
   assign out_valid      = rd.RdDataValid & busy;
   assign rd.RdDataReady = out_ready & busy;
   assign out_data       = rd.RdDataPayload.data[8*DATA_BYTES-1:0];
   assign out_last       = out_valid && (beats_rcvd_q == beats_total_q - LEN_W'(1));

   assign rd.RdAddrValid   = ar_valid_q;
   assign rd.RdAddrPayload = ar_q;

   assign ar_hs     = ar_valid_q & rd.RdAddrReady;
   assign r_hs      = out_valid & out_ready;
   assign r_last_hs = r_hs & rd.RdDataPayload.last;

   assign unused_r_fields = ^{rd.RdDataPayload.id, rd.RdDataPayload.resp[0]};

   always_comb begin
      // NOTE: every variable gets a default here so no path can infer a latch.
      state_d       = state_q;
      cur_addr_d    = cur_addr_q;
      remaining_d   = remaining_q;
      beats_total_d = beats_total_q;
      beats_rcvd_d  = beats_rcvd_q;
      ar_valid_d    = ar_valid_q;
      ar_d          = ar_q;
      err_d         = err_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               cur_addr_d    = cmd_addr & ALIGN_MASK;
               remaining_d   = cmd_beats;
               beats_total_d = cmd_beats;
               beats_rcvd_d  = '0;
               err_d         = 1'b0;
               state_d       = (cmd_beats == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (ar_hs) begin
               ar_valid_d  = 1'b0;
               cur_addr_d  = cur_addr_q + (ADDR_W'(cur_beats) << SHIFT);
               remaining_d = remaining_q - cur_beats;
               if (remaining_q == cur_beats) state_d = DRAIN;
            end else if (!ar_valid_q && (outst_q != OUT_W'(MAX_OUTST))) begin
               ar_valid_d = 1'b1;
               ar_d.id    = AXI_ID_W'(AXI_ID);
               ar_d.addr  = AXI_ADDR_W'(cur_addr_q);
               ar_d.len   = 8'(burst_beats - 13'd1);
               ar_d.size  = 3'(SHIFT);
               ar_d.burst = BURST_INCR;
            end
         end
         DRAIN: begin
            if ((outst_q == '0) && (beats_rcvd_q == beats_total_q)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // r_hs is never set in IDLE, so this cannot collide with the command load.
      if (r_hs) begin
         beats_rcvd_d = beats_rcvd_q + LEN_W'(1);
         if (rd.RdDataPayload.resp[1]) err_d = 1'b1;
      end
   end

   always_comb begin
      outst_d = outst_q;
      case ({ar_hs, r_last_hs})
         2'b10:   outst_d = outst_q + OUT_W'(1);
         2'b01:   outst_d = outst_q - OUT_W'(1);
         default: outst_d = outst_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= IDLE;
         cur_addr_q    <= '0;
         remaining_q   <= '0;
         beats_total_q <= '0;
         beats_rcvd_q  <= '0;
         outst_q       <= '0;
         ar_valid_q    <= 1'b0;
         ar_q          <= '0;
         err_q         <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so all flops sample pre-edge values together.
         state_q       <= state_d;
         cur_addr_q    <= cur_addr_d;
         remaining_q   <= remaining_d;
         beats_total_q <= beats_total_d;
         beats_rcvd_q  <= beats_rcvd_d;
         outst_q       <= outst_d;
         ar_valid_q    <= ar_valid_d;
         ar_q          <= ar_d;
         err_q         <= err_d;
      end
   end

endmodule

// File: tb/tb_dma_rd_burst_engine.sv
// -----------------------------------------------------------------------------
// tb_dma_rd_burst_engine
// Purpose : Directed bench for dma_rd_burst_engine with a small AXI read slave,
//           a transfer-level reference model and a per-cycle compare process.
// -----------------------------------------------------------------------------
module tb_dma_rd_burst_engine;
   import AxiPkg::*;

   localparam int DB   = 8;
   localparam int MAXB = 16;
   localparam int MAXO = 4;

   typedef struct {
      logic [63:0] addr;
      int          len;
   } ar_t;

   logic        clk;
   logic        rstn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [63:0] cmd_addr;
   logic [31:0] cmd_bytes;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;
   logic        err;

   AXI4ReadIntf rd_if ();

   dma_rd_burst_engine #(
      .DATA_BYTES(DB), .ADDR_W(64), .LEN_W(32),
      .MAX_BURST(MAXB), .MAX_OUTST(MAXO), .AXI_ID(0)
   ) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_bytes(cmd_bytes),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done), .err(err),
      .rd(rd_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] beat_data(input logic [63:0] a);
      return {~a[31:0], a[31:0]};
   endfunction

   // ---------------- slave controls and state ----------------
   bit          hold_r     = 1'b0;
   int          ar_stall   = 0;
   logic [63:0] err_addr   = '1;
   bit          rand_ready = 1'b0;
   bit          rand_rgap  = 1'b0;
   ar_t         r_q[$];
   int          r_beat     = 0;
   int          stall_cnt  = 0;
   logic [63:0] slv_a;

   // Slave drives its outputs on the falling edge, then books handshakes.
   initial begin
      rd_if.RdAddrReady   = 1'b0;
      rd_if.RdDataValid   = 1'b0;
      rd_if.RdDataPayload = '0;
      out_ready           = 1'b0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            r_q.delete();
            r_beat              = 0;
            stall_cnt           = 0;
            rd_if.RdAddrReady   = 1'b0;
            rd_if.RdDataValid   = 1'b0;
            rd_if.RdDataPayload = '0;
            continue;
         end
         if (rd_if.RdAddrValid && stall_cnt < ar_stall) begin
            rd_if.RdAddrReady = 1'b0;
            stall_cnt++;
         end else begin
            rd_if.RdAddrReady = 1'b1;
         end
         if (!hold_r && r_q.size() > 0 && !(rand_rgap && $urandom_range(0, 3) == 0)) begin
            slv_a                    = r_q[0].addr + 64'(r_beat * DB);
            rd_if.RdDataValid        = 1'b1;
            rd_if.RdDataPayload.id   = '0;
            rd_if.RdDataPayload.data = beat_data(slv_a);
            rd_if.RdDataPayload.resp = (slv_a == err_addr) ? 2'b10 : 2'b00;
            rd_if.RdDataPayload.last = (r_beat == r_q[0].len);
         end else begin
            rd_if.RdDataValid   = 1'b0;
            rd_if.RdDataPayload = '0;
         end
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         #2;
         if (rd_if.RdAddrValid && rd_if.RdAddrReady) begin
            r_q.push_back('{rd_if.RdAddrPayload.addr, int'(rd_if.RdAddrPayload.len)});
            stall_cnt = 0;
         end
         if (rd_if.RdDataValid && rd_if.RdDataReady) begin
            if (rd_if.RdDataPayload.last) begin
               void'(r_q.pop_front());
               r_beat = 0;
            end else begin
               r_beat++;
            end
         end
      end
   end

   // ---------------- transfer-level reference model ----------------
   ar_t         exp_ar[$];
   ar_t         ar_log[$];
   int          m_total, m_fwd, m_outst;
   int          done_cnt, stall_cycles, last_idx;
   logic [63:0] m_start;
   bit          m_active, m_err, prev_wait, saw_arvalid;
   AxiRdAddr_t  prev_pl;

   // Expected burst list straight from the splitting rules.
   function automatic void build_ars(input logic [63:0] a0, input logic [31:0] bytes);
      logic [63:0] a;
      longint      n, room, b;
      a = a0 & ~64'(DB - 1);
      n = longint'(bytes) / DB;
      while (n > 0) begin
         room = (4096 - longint'(a[11:0])) / DB;
         b = n;
         if (b > MAXB) b = MAXB;
         if (b > room) b = room;
         exp_ar.push_back('{a, int'(b - 1)});
         a = a + 64'(b * DB);
         n = n - b;
      end
   endfunction

   initial begin
      ar_t e;
      bit  exp_last;
      m_total = 0; m_fwd = 0; m_outst = 0; m_active = 0; m_err = 0;
      prev_wait = 0; prev_pl = '0; m_start = '0;
      forever begin
         @(negedge clk);
         #3;
         if (!rstn) begin
            exp_ar.delete();
            m_total = 0; m_fwd = 0; m_outst = 0; m_active = 0; m_err = 0;
            prev_wait = 0;
            continue;
         end
         check("cmd_ready_vs_busy", 64'(cmd_ready), 64'(!busy));
         if (m_active) check("busy", 64'(busy), 64'd1);
         check("err", 64'(err), 64'(m_err));
         if (prev_wait) begin
            check("ar_hold_valid", 64'(rd_if.RdAddrValid), 64'd1);
            check("ar_hold_payload", 64'(rd_if.RdAddrPayload ^ prev_pl), 64'd0);
         end
         if (rd_if.RdAddrValid) saw_arvalid = 1'b1;
         check("ar_gated_at_max_outst", 64'(rd_if.RdAddrValid && m_outst >= MAXO), 64'd0);

         if (rd_if.RdAddrValid && rd_if.RdAddrReady) begin
            if (exp_ar.size() == 0) begin
               check("ar_extra", 64'd1, 64'd0);
            end else begin
               e = exp_ar.pop_front();
               check("ar_addr", rd_if.RdAddrPayload.addr, e.addr);
               check("ar_len", 64'(rd_if.RdAddrPayload.len), 64'(e.len));
               check("ar_size", 64'(rd_if.RdAddrPayload.size), 64'd3);
               check("ar_burst", 64'(rd_if.RdAddrPayload.burst), 64'd1);
               check("ar_id", 64'(rd_if.RdAddrPayload.id), 64'd0);
            end
            ar_log.push_back('{rd_if.RdAddrPayload.addr, int'(rd_if.RdAddrPayload.len)});
            m_outst++;
         end
         if (rd_if.RdAddrValid && !rd_if.RdAddrReady) stall_cycles++;

         if (out_valid) begin
            check("beat_in_transfer", 64'(m_active), 64'd1);
            exp_last = (m_fwd == m_total - 1);
            check("out_last", 64'(out_last), 64'(exp_last));
            if (out_ready) begin
               check("beat_within_total", 64'(m_fwd < m_total), 64'd1);
               check("out_data", out_data,
                     beat_data((m_start & ~64'(DB - 1)) + 64'(m_fwd * DB)));
               if (out_last) last_idx = m_fwd;
               m_fwd++;
               if (rd_if.RdDataPayload.resp[1]) m_err = 1'b1;
               if (rd_if.RdDataPayload.last) m_outst--;
            end
         end

         if (done) begin
            check("done_when_complete",
                  64'(m_fwd == m_total && exp_ar.size() == 0 && m_outst == 0), 64'd1);
            done_cnt++;
            m_active = 1'b0;
         end

         if (cmd_valid && cmd_ready) begin
            exp_ar.delete();
            m_active = 1'b1;
            m_start  = cmd_addr;
            m_total  = int'(cmd_bytes / DB);
            m_fwd    = 0;
            m_err    = 1'b0;
            build_ars(cmd_addr, cmd_bytes);
         end

         prev_wait = rd_if.RdAddrValid && !rd_if.RdAddrReady;
         prev_pl   = rd_if.RdAddrPayload;
      end
   end

   // ---------------- directed sequence ----------------
   task automatic start_cmd(input logic [63:0] a, input logic [31:0] b);
      int n;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) check("cmd_ready_timeout", 64'd0, 64'd1);
      ar_log.delete();
      done_cnt = 0; stall_cycles = 0; last_idx = -1; saw_arvalid = 1'b0;
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_bytes = b;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(negedge clk);
         #4;
         n++;
      end
      repeat (3) @(negedge clk);
      #4;
      check("done_pulse_count", 64'(done_cnt), 64'd1);
   endtask

   task automatic check_ar(input int idx, input logic [63:0] a, input int len);
      if (idx < ar_log.size()) begin
         check("ar_log_addr", ar_log[idx].addr, a);
         check("ar_log_len", 64'(ar_log[idx].len), 64'(len));
      end else begin
         check("ar_log_missing", 64'(ar_log.size()), 64'(idx + 1));
      end
   endtask

   task automatic check_reset_values();
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_arvalid", 64'(rd_if.RdAddrValid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_bytes = '0;
      rstn      = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_reset_values();
      #3 rstn = 1'b1;

      // 256 bytes from 0x1000: two full bursts.
      start_cmd(64'h1000, 32'd256);
      wait_done(400);
      check("t1_ar_count", 64'(ar_log.size()), 64'd2);
      check_ar(0, 64'h1000, 15);
      check_ar(1, 64'h1080, 15);
      check("t1_beats", 64'(m_fwd), 64'd32);
      check("t1_last_idx", 64'(last_idx), 64'd31);

      // 4 KiB split.
      start_cmd(64'h0FC0, 32'd128);
      wait_done(400);
      check("t2_ar_count", 64'(ar_log.size()), 64'd2);
      check_ar(0, 64'h0FC0, 7);
      check_ar(1, 64'h1000, 7);
      check("t2_beats", 64'(m_fwd), 64'd16);

      // Zero-length transfer.
      start_cmd(64'h7000, 32'd0);
      #1;
      check("t3_done_next_cycle", 64'(done), 64'd1);
      wait_done(20);
      check("t3_no_arvalid", 64'(saw_arvalid), 64'd0);

      // R held off: outstanding limit stops AR issue.
      hold_r = 1'b1;
      start_cmd(64'h8000, 32'd1024);
      repeat (30) @(negedge clk);
      #4;
      check("t4_ar_at_limit", 64'(ar_log.size()), 64'd4);
      check("t4_arvalid_low", 64'(rd_if.RdAddrValid), 64'd0);
      hold_r = 1'b0;
      wait_done(2000);
      check("t4_ar_total", 64'(ar_log.size()), 64'd8);
      check("t4_beats", 64'(m_fwd), 64'd128);

      // AR ready held low 5 cycles per burst.
      ar_stall = 5;
      start_cmd(64'h2000, 32'd256);
      wait_done(400);
      check("t5_stall_cycles", 64'(stall_cycles), 64'd10);
      ar_stall = 0;

      // SLVERR on beat 3 of 16.
      err_addr = 64'h3010;
      start_cmd(64'h3000, 32'd128);
      wait_done(400);
      check("t6_err_set", 64'(err), 64'd1);
      check("t6_beats", 64'(m_fwd), 64'd16);
      err_addr = '1;
      start_cmd(64'h4000, 32'd64);
      #1;
      check("t6_err_cleared", 64'(err), 64'd0);
      wait_done(400);

      // Random backpressure and R gaps, unaligned start and odd length.
      rand_ready = 1'b1;
      rand_rgap  = 1'b1;
      start_cmd(64'h5FC3, 32'd1005);
      wait_done(5000);
      check("t7_beats", 64'(m_fwd), 64'd125);
      check("t7_ar_count", 64'(ar_log.size()), 64'd9);
      check_ar(0, 64'h5FC0, 7);
      check_ar(8, 64'h6380, 4);
      rand_ready = 1'b0;
      rand_rgap  = 1'b0;

      // Reset while draining.
      hold_r = 1'b1;
      start_cmd(64'h9000, 32'd256);
      repeat (10) @(negedge clk);
      #4;
      check("t8_busy_in_drain", 64'(busy), 64'd1);
      check("t8_ars_issued", 64'(ar_log.size()), 64'd2);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check_reset_values();
      @(negedge clk);
      #1;
      check_reset_values();
      hold_r = 1'b0;
      #3 rstn = 1'b1;

      // Recovery after reset.
      start_cmd(64'hA000, 32'd64);
      wait_done(400);
      check("t9_beats", 64'(m_fwd), 64'd8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
